inta_sequencer: RTL and testbench

Clocked interrupt-acknowledge sequencer sitting between the CPU's active-low INTA line and the priority resolver. It turns each two-pulse INTA cycle into single-cycle strobes (imp1, endOfimp1, imp2, endOfimp2) that the priority resolver consumes to load ISR, place the vector and perform auto-EOI. It also generates the data-bus output enable for the vector byte, including cascade master/slave qualification. A watchdog aborts a half-finished acknowledge.

---
 rtl/inta_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_inta_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// -----------------------------------------------------------------------------
// inta_sequencer
//
// Purpose:
//   Converts the CPU's two-pulse, active-low INTA acknowledge cycle into
//   single-cycle strobes for the priority resolver. The resolver uses them
//   to load ISR, place the vector and perform auto-EOI. The block also
//   generates the data-bus output enable for the vector byte, with cascade
//   master/slave qualification. A watchdog aborts an acknowledge whose
//   second INTA pulse never arrives.
//
// Parameters:
//   TIMEOUT    maximum cycles between endOfimp1 and the second INTA fall;
//              0 disables the watchdog.
//
// Build option:
//   INTA_SYNC_EN   when defined, INTA_n passes through a two-flop
//                  synchronizer before edge detection, so strobes appear
//                  3 edges after INTA_n is sampled. When undefined, INTA_n
//                  must already be synchronous to clk and the latency is
//                  1 edge.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   INTA_n     in   CPU acknowledge, active low
//   INT        in   interrupt request from the priority resolver
//   endOfinit  in   initialisation complete; INTA is ignored while 0
//   SNGL       in   ICW1 single mode
//   en         in   1 = cascade master, 0 = cascade slave
//   cas_match  in   slave addressed (CAS lines equal the ICW3 ID)
//   slave_ir   in   master only: the acknowledged IR has a slave attached
//   imp1       out  strobe: first INTA fall accepted
//   endOfimp1  out  strobe: first INTA rise
//   imp2       out  strobe: second INTA fall
//   endOfimp2  out  strobe: second INTA rise, acknowledge complete
//   data_oe    out  drive the vector byte onto the data bus
//   busy       out  acknowledge sequence in progress
//   spurious   out  INT was 0 at the first INTA fall; held until IDLE
//   abort      out  strobe: watchdog expired in GAP
//   state_o    out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module inta_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       INTA_n,
    input  logic       INT,
    input  logic       endOfinit,
    input  logic       SNGL,
    input  logic       en,
    input  logic       cas_match,
    input  logic       slave_ir,
    output logic       imp1,
    output logic       endOfimp1,
    output logic       imp2,
    output logic       endOfimp2,
    output logic       data_oe,
    output logic       busy,
    output logic       spurious,
    output logic       abort,
    output logic [1:0] state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK1 = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_ACK2 = 2'd3;

    localparam int              WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);

    // INTA protocol: each acknowledge is fall/rise/fall/rise of INTA_n, with
    // every low and high phase lasting at least two clk periods. Edges that
    // cannot occur in the current state are ignored.
    logic inta_s;

`ifdef INTA_SYNC_EN
    logic sync1_q, sync2_q;

    // Preset to 1 so a reset never produces a false falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= INTA_n;
            sync2_q <= sync1_q;
        end
    end

    assign inta_s = sync2_q;
`else
    assign inta_s = INTA_n;
`endif

    logic inta_q;
    logic fall, rise;

    always_ff @(posedge clk) begin
        if (rst) inta_q <= 1'b1;
        else     inta_q <= inta_s;
    end

    assign fall = inta_q & ~inta_s;
    assign rise = ~inta_q & inta_s;

    logic [1:0]      state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            spur_q, spur_d;
    logic            imp1_q, imp1_d;
    logic            eoi1_q, eoi1_d;
    logic            imp2_q, imp2_d;
    logic            eoi2_q, eoi2_d;
    logic            abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        spur_d  = spur_q;
        imp1_d  = 1'b0;
        eoi1_d  = 1'b0;
        imp2_d  = 1'b0;
        eoi2_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall && endOfinit) begin
                    state_d = S_ACK1;
                    imp1_d  = 1'b1;
                    spur_d  = ~INT;
                end
            end
            S_ACK1: begin
                if (rise) begin
                    state_d = S_GAP;
                    eoi1_d  = 1'b1;
                    wd_d    = WD_LOAD;
                end
            end
            S_GAP: begin
                // A fall seen in the expiry cycle takes priority over abort.
                if (fall) begin
                    state_d = S_ACK2;
                    imp2_d  = 1'b1;
                    wd_d    = '0;
                end else if ((TIMEOUT > 0) && (wd_q == '0)) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                    spur_d  = 1'b0;
                end else if (wd_q != '0) begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            S_ACK2: begin
                if (rise) begin
                    state_d = S_IDLE;
                    eoi2_d  = 1'b1;
                    spur_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            spur_q  <= 1'b0;
            imp1_q  <= 1'b0;
            eoi1_q  <= 1'b0;
            imp2_q  <= 1'b0;
            eoi2_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            spur_q  <= spur_d;
            imp1_q  <= imp1_d;
            eoi1_q  <= eoi1_d;
            imp2_q  <= imp2_d;
            eoi2_q  <= eoi2_d;
            abort_q <= abort_d;
        end
    end

    assign imp1      = imp1_q;
    assign endOfimp1 = eoi1_q;
    assign imp2      = imp2_q;
    assign endOfimp2 = eoi2_q;
    assign abort     = abort_q;
    assign spurious  = spur_q;
    assign busy      = (state_q != S_IDLE);
    assign state_o   = state_q;

    // Cascade qualification is combinational so that CAS/ICW changes during
    // ACK2 are reflected immediately on the bus enable.
    assign data_oe = (state_q == S_ACK2) &
                     (SNGL | (~en & cas_match) | (en & ~slave_ir));

endmodule

// File: tb/tb_inta_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inta_sequencer
//
// Bench for inta_sequencer (TIMEOUT = 8). Each scenario drives an INTA
// waveform and pushes the events it should cause (strobes plus rising and
// falling edges of data_oe, busy and spurious), tagged with the clock edge
// after which each should be visible. A negedge monitor turns DUT activity
// into the same event records and pops the queue in order.
// -----------------------------------------------------------------------------
module tb_inta_sequencer;

    localparam int TO = 8;
`ifdef INTA_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    // Event ids
    localparam int EV_IMP1 = 1;
    localparam int EV_EOI1 = 2;
    localparam int EV_IMP2 = 3;
    localparam int EV_EOI2 = 4;
    localparam int EV_ABRT = 5;
    localparam int EV_OE_R = 6;
    localparam int EV_OE_F = 7;
    localparam int EV_BS_R = 8;
    localparam int EV_BS_F = 9;
    localparam int EV_SP_R = 10;
    localparam int EV_SP_F = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, INTA_n, INT, endOfinit, SNGL, en, cas_match, slave_ir;
    logic imp1, endOfimp1, imp2, endOfimp2, data_oe, busy, spurious, abort;
    logic [1:0] state_o;

    inta_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .INTA_n(INTA_n), .INT(INT),
        .endOfinit(endOfinit), .SNGL(SNGL), .en(en),
        .cas_match(cas_match), .slave_ir(slave_ir),
        .imp1(imp1), .endOfimp1(endOfimp1), .imp2(imp2),
        .endOfimp2(endOfimp2), .data_oe(data_oe), .busy(busy),
        .spurious(spurious), .abort(abort), .state_o(state_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;
    logic p_oe = 1'b0, p_busy = 1'b0, p_spur = 1'b0;

    function automatic logic [19:0] mk_ev(input int c, input int id);
        return {16'(c), 4'(id)};
    endfunction

    always @(negedge clk) begin
        bit ev_v[12];
        int nstb;
        logic [19:0] got, e;
        if (mon_en) begin
            for (int i = 0; i < 12; i++) ev_v[i] = 1'b0;
            ev_v[EV_IMP1] = imp1;
            ev_v[EV_EOI1] = endOfimp1;
            ev_v[EV_IMP2] = imp2;
            ev_v[EV_EOI2] = endOfimp2;
            ev_v[EV_ABRT] = abort;
            ev_v[EV_OE_R] = data_oe & ~p_oe;
            ev_v[EV_OE_F] = ~data_oe & p_oe;
            ev_v[EV_BS_R] = busy & ~p_busy;
            ev_v[EV_BS_F] = ~busy & p_busy;
            ev_v[EV_SP_R] = spurious & ~p_spur;
            ev_v[EV_SP_F] = ~spurious & p_spur;
            for (int id = 1; id < 12; id++) begin
                if (ev_v[id]) begin
                    got = mk_ev(cyc, id);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL event: got cycle %0d id %0d, required none", cyc, id);
                    end else begin
                        e = exp_q.pop_front();
                        if (e !== got) begin
                            n_err++;
                            $display("FAIL event: got cycle %0d id %0d, required cycle %0d id %0d",
                                     cyc, id, e[19:4], e[3:0]);
                        end
                    end
                end
            end
            nstb = int'(imp1) + int'(endOfimp1) + int'(imp2) + int'(endOfimp2) + int'(abort);
            if (nstb != 0) begin
                n_cmp++;
                if (nstb > 1) begin
                    n_err++;
                    $display("FAIL one_strobe: cycle %0d has %0d strobes, required 1", cyc, nstb);
                end
            end
        end
        p_oe   = data_oe;
        p_busy = busy;
        p_spur = spurious;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic v);
        INTA_n = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_empty(input string tag);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected events not seen, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        logic [7:0] o;
        o = {imp1, endOfimp1, imp2, endOfimp2, data_oe, busy, spurious, abort};
        n_cmp++;
        if (o !== 8'h00) begin
            n_err++;
            $display("FAIL %s: outputs %b, required 00000000", tag, o);
        end
    endtask

    typedef struct {
        logic eoi;
        logic int_r;
        logic sngl;
        logic en_r;
        logic cas;
        logic sir;
        int   low1;
        int   high1;
        int   low2;   // 0: no second pulse, watchdog must abort
        logic oe_exp;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v, input string tag);
        int f1, r1, f2, r2, a;
        INT       = v.int_r;
        SNGL      = v.sngl;
        en        = v.en_r;
        cas_match = v.cas;
        slave_ir  = v.sir;
        endOfinit = v.eoi;
        step(1'b1);
        step(1'b1);
        f1 = cyc + 1;
        r1 = f1 + v.low1;
        f2 = r1 + v.high1;
        r2 = f2 + v.low2;
        if (v.eoi) begin
            exp_q.push_back(mk_ev(f1 + D, EV_IMP1));
            exp_q.push_back(mk_ev(f1 + D, EV_BS_R));
            if (!v.int_r) exp_q.push_back(mk_ev(f1 + D, EV_SP_R));
            exp_q.push_back(mk_ev(r1 + D, EV_EOI1));
            if (v.low2 > 0) begin
                exp_q.push_back(mk_ev(f2 + D, EV_IMP2));
                if (v.oe_exp) exp_q.push_back(mk_ev(f2 + D, EV_OE_R));
                exp_q.push_back(mk_ev(r2 + D, EV_EOI2));
                if (v.oe_exp) exp_q.push_back(mk_ev(r2 + D, EV_OE_F));
                exp_q.push_back(mk_ev(r2 + D, EV_BS_F));
                if (!v.int_r) exp_q.push_back(mk_ev(r2 + D, EV_SP_F));
            end else begin
                a = r1 + D + TO + 1;
                exp_q.push_back(mk_ev(a, EV_ABRT));
                exp_q.push_back(mk_ev(a, EV_BS_F));
                if (!v.int_r) exp_q.push_back(mk_ev(a, EV_SP_F));
            end
        end
        repeat (v.low1) step(1'b0);
        if (v.low2 > 0) begin
            repeat (v.high1) step(1'b1);
            repeat (v.low2) step(1'b0);
        end else begin
            repeat (TO + 6) step(1'b1);
        end
        repeat (D + 4) step(1'b1);
        check_empty(tag);
        endOfinit = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        int f1, x;
        //          eoi   int   sngl  en    cas   sir   l1 h1 l2  oe
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 6, 4, 1'b1}; // single mode
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 6, 4, 1'b0}; // not initialised
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 0, 1'b0}; // watchdog abort
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3, 3, 1'b0}; // slave, not addressed
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 2, 1'b1}; // slave addressed, min widths
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 4, 3, 1'b0}; // master, slave on IR
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 4, 3, 1'b1}; // master, no slave
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 5, 4, 1'b1}; // spurious
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, TO + 1, 2, 1'b1}; // fall in expiry cycle
        for (int i = 9; i < 12; i++) begin
            vecs[i].eoi   = 1'b1;
            vecs[i].int_r = 1'($urandom_range(0, 1));
            vecs[i].sngl  = 1'($urandom_range(0, 1));
            vecs[i].en_r  = 1'($urandom_range(0, 1));
            vecs[i].cas   = 1'($urandom_range(0, 1));
            vecs[i].sir   = 1'($urandom_range(0, 1));
            vecs[i].low1  = $urandom_range(2, 5);
            vecs[i].high1 = $urandom_range(2, TO + 1);
            vecs[i].low2  = $urandom_range(2, 5);
            vecs[i].oe_exp = vecs[i].sngl | (~vecs[i].en_r & vecs[i].cas) |
                             (vecs[i].en_r & ~vecs[i].sir);
        end

        rst = 1'b1; INTA_n = 1'b1; INT = 1'b1; endOfinit = 1'b1;
        SNGL = 1'b1; en = 1'b1; cas_match = 1'b0; slave_ir = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_outputs_zero("reset_held");
        rst = 1'b0;
        step(1'b1);
        check_outputs_zero("after_reset");
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while waiting in GAP, then a normal acknowledge.
        INT = 1'b1; SNGL = 1'b1; en = 1'b1; cas_match = 1'b0; slave_ir = 1'b0;
        step(1'b1);
        f1 = cyc + 1;
        exp_q.push_back(mk_ev(f1 + D, EV_IMP1));
        exp_q.push_back(mk_ev(f1 + D, EV_BS_R));
        exp_q.push_back(mk_ev(f1 + 3 + D, EV_EOI1));
        repeat (3) step(1'b0);
        repeat (D + 3) step(1'b1);
        x = cyc + 1;
        exp_q.push_back(mk_ev(x, EV_BS_F));
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        check_outputs_zero("rst_in_gap");
        run_vec(vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
